// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with a bounded MEM_WAIT FSM.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int MAX_MEM_WAIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REG_ADDR_LEN-1:0] id_rs_addr,
  input  logic [REG_ADDR_LEN-1:0] id_rt_addr,
  input  logic                    id_uses_rs,
  input  logic                    id_uses_rt,
  input  logic                    ex_mem_read_flag,
  input  logic [REG_ADDR_LEN-1:0] ex_rt_addr,
  input  logic                    ex_branch_taken,
  input  logic                    ex_jump_flag,
  input  logic                    mem_req,
  input  logic                    mem_ack,
  input  logic                    timeout_clr,
  output logic                    pc_stall,
  output logic                    if_id_stall,
  output logic                    if_id_flush,
  output logic                    id_ex_stall,
  output logic                    id_ex_flush,
  output logic                    ex_mem_stall,
  output logic                    mem_wb_bubble,
  output logic [1:0]              ctrl_state,
  output logic                    mem_timeout,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
);

  localparam int WCW = (MAX_MEM_WAIT > 2) ? $clog2(MAX_MEM_WAIT) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(MAX_MEM_WAIT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_RECOVER  = 2'd2
  } state_t;

  state_t         r_state;
  logic [WCW-1:0] r_wait_cnt;
  logic           r_timeout;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;
  logic w_redirect;
  logic w_mem_miss;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  //  id_ex_flush, ex_mem_stall, mem_wb_bubble}
  logic [6:0] w_run_vec;
  logic [6:0] w_raw_vec;

  localparam logic [6:0] V_NONE   = 7'b0000000;
  localparam logic [6:0] V_FREEZE = 7'b1101011;
  localparam logic [6:0] V_REDIR  = 7'b0010100;
  localparam logic [6:0] V_LDUSE  = 7'b1100100;
  localparam logic [6:0] V_RECOV  = 7'b0010101;

  assign w_rs_hit   = id_uses_rs && (id_rs_addr == ex_rt_addr);
  assign w_rt_hit   = id_uses_rt && (id_rt_addr == ex_rt_addr);
  assign w_load_use = ex_mem_read_flag && (ex_rt_addr != '0)
                      && (w_rs_hit || w_rt_hit);
  assign w_redirect = ex_branch_taken || ex_jump_flag;
  assign w_mem_miss = mem_req && !mem_ack;

  // Decode used in RUN (after the miss check) and on the MEM_WAIT ack cycle.
  always_comb begin
    w_run_vec = V_NONE;
    if (w_redirect) begin
      w_run_vec = V_REDIR;
    end else if (w_load_use) begin
      w_run_vec = V_LDUSE;
    end
  end

  always_comb begin
    w_raw_vec = V_NONE;
    if (rst_n) begin
      case (r_state)
        S_MEM_WAIT: w_raw_vec = mem_ack ? w_run_vec : V_FREEZE;
        S_RECOVER:  w_raw_vec = V_RECOV;
        default:    w_raw_vec = w_mem_miss ? V_FREEZE : w_run_vec;
      endcase
    end
  end

  assign if_id_flush   = w_raw_vec[4];
  assign id_ex_flush   = w_raw_vec[2];
  assign pc_stall      = w_raw_vec[6];
  assign if_id_stall   = w_raw_vec[5] && !if_id_flush;
  assign id_ex_stall   = w_raw_vec[3] && !id_ex_flush;
  assign ex_mem_stall  = w_raw_vec[1];
  assign mem_wb_bubble = w_raw_vec[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (timeout_clr) begin
        r_timeout <= 1'b0;
      end
      case (r_state)
        S_MEM_WAIT: begin
          if (mem_ack) begin
            r_state <= S_RUN;
          end else if (r_wait_cnt == WC_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_RECOVER;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RECOVER: begin
          r_state <= S_RUN;
        end
        default: begin
          r_state <= S_RUN;
          if (w_mem_miss) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign ctrl_state  = r_state;
  assign mem_timeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_flush_any;

  assign w_flush_any = if_id_flush || id_ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_flush_any && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MAX_MEM_WAIT=4).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_rt_addr;
  logic        id_uses_rs, id_uses_rt, ex_mem_read_flag;
  logic        ex_branch_taken, ex_jump_flag;
  logic        mem_req, mem_ack, timeout_clr;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic        id_ex_flush, ex_mem_stall, mem_wb_bubble, mem_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] FRZ   = 7'b1101011;
  localparam logic [6:0] REDIR = 7'b0010100;
  localparam logic [6:0] LU    = 7'b1100100;
  localparam logic [6:0] REC   = 7'b0010101;

  pipeline_hazard_ctrl #(.REG_ADDR_LEN(5), .MAX_MEM_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read_flag(ex_mem_read_flag), .ex_rt_addr(ex_rt_addr),
    .ex_branch_taken(ex_branch_taken), .ex_jump_flag(ex_jump_flag),
    .mem_req(mem_req), .mem_ack(mem_ack), .timeout_clr(timeout_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .ctrl_state(ctrl_state),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
            id_ex_flush, ex_mem_stall, mem_wb_bubble};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [6:0] v,
                         input logic [1:0] st, input logic to);
    chk({tag, ".outs"}, {25'd0, outs()}, {25'd0, v});
    chk({tag, ".state"}, {30'd0, ctrl_state}, {30'd0, st});
    chk({tag, ".tmo"}, {31'd0, mem_timeout}, {31'd0, to});
  endtask

  task automatic clr_in();
    id_rs_addr = 0; id_rt_addr = 0; ex_rt_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read_flag = 0;
    ex_branch_taken = 0; ex_jump_flag = 0;
    mem_req = 0; mem_ack = 0; timeout_clr = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    ex_mem_read_flag = 1; ex_rt_addr = 5;
    id_rs_addr = 5; id_uses_rs = 1;
  endtask

  initial begin
    clr_in();
    rst_n = 0;
    mem_req = 1;
    set_lu();
    #12;
    chk_cyc("reset", NONE, 2'd0, 1'b0);
    chk("reset.scnt", stall_cnt, 32'd0);
    chk("reset.fcnt", flush_cnt, 32'd0);
    clr_in();
    #2 rst_n = 1;

    tick(); set_lu(); #3;
    chk_cyc("ld_use", LU, 2'd0, 1'b0);
    tick(); set_lu(); ex_branch_taken = 1; #3;
    chk_cyc("redir_lu", REDIR, 2'd0, 1'b0);
    tick(); clr_in(); #3;
    chk_cyc("idle", NONE, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.scnt", stall_cnt, 32'd1);
    chk("perf.fcnt", flush_cnt, 32'd2);
`else
    chk("perf.scnt", stall_cnt, 32'd0);
    chk("perf.fcnt", flush_cnt, 32'd0);
`endif

    tick(); set_lu(); ex_rt_addr = 0; id_rs_addr = 0; #3;
    chk_cyc("ld_use_r0", NONE, 2'd0, 1'b0);
    tick(); clr_in(); ex_mem_read_flag = 1; ex_rt_addr = 7;
    id_rt_addr = 7; id_uses_rt = 1; #3;
    chk_cyc("ld_use_rt", LU, 2'd0, 1'b0);
    tick(); id_uses_rt = 0; #3;
    chk_cyc("ld_use_nort", NONE, 2'd0, 1'b0);
    tick(); clr_in(); ex_jump_flag = 1; #3;
    chk_cyc("jump", REDIR, 2'd0, 1'b0);

    // Miss: entry cycle + 3 wait cycles, then ack with a pending branch.
    tick(); clr_in(); mem_req = 1; ex_branch_taken = 1; #3;
    chk_cyc("mw.entry", FRZ, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); #3;
      chk_cyc("mw.wait", FRZ, 2'd1, 1'b0);
    end
    tick(); mem_ack = 1; #3;
    chk_cyc("mw.ack", REDIR, 2'd1, 1'b0);
    tick(); clr_in(); #3;
    chk_cyc("mw.done", NONE, 2'd0, 1'b0);

    // Timeout: 4 MEM_WAIT cycles then RECOVER, inputs ignored there.
    tick(); mem_req = 1; #3;
    chk_cyc("to.entry", FRZ, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); #3;
      chk_cyc("to.wait", FRZ, 2'd1, 1'b0);
    end
    tick(); set_lu(); ex_jump_flag = 1; #3;
    chk_cyc("to.recover", REC, 2'd2, 1'b1);
    tick(); clr_in(); #3;
    chk_cyc("to.run", NONE, 2'd0, 1'b1);
    tick(); timeout_clr = 1; #3;
    chk_cyc("to.clr_cyc", NONE, 2'd0, 1'b1);
    tick(); timeout_clr = 0; #3;
    chk_cyc("to.cleared", NONE, 2'd0, 1'b0);

    // Set beats a simultaneous clear.
    tick(); mem_req = 1; timeout_clr = 1; #3;
    chk_cyc("sw.entry", FRZ, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); #3;
      chk_cyc("sw.wait", FRZ, 2'd1, 1'b0);
    end
    tick(); mem_req = 0; #3;
    chk_cyc("sw.recover", REC, 2'd2, 1'b1);
    tick(); timeout_clr = 0; #3;
    chk_cyc("sw.cleared", NONE, 2'd0, 1'b0);

    // Async reset in the middle of MEM_WAIT.
    tick(); mem_req = 1; #3;
    chk_cyc("ar.entry", FRZ, 2'd0, 1'b0);
    tick(); #1;
    chk_cyc("ar.wait", FRZ, 2'd1, 1'b0);
    rst_n = 0; #1;
    chk_cyc("ar.inrst", NONE, 2'd0, 1'b0);
    #4 clr_in();
    #2 rst_n = 1;
    tick(); #3;
    chk_cyc("ar.run", NONE, 2'd0, 1'b0);
    tick(); mem_req = 1; mem_ack = 1; #3;
    chk_cyc("ar.hit", NONE, 2'd0, 1'b0);
    tick(); clr_in(); #3;
    chk_cyc("ar.stay", NONE, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
